// File: rtl/reg_file_rename_pkg.sv
// Shared constants for the architectural register file and its rename tags.
// Mirrors the ROB/register widths used across the Tomasulo core.
package reg_file_rename_pkg;

   localparam int unsigned ROB_WIDTH_BIT = 4;
   localparam int unsigned REG_NUM_BIT   = 5;
   localparam int unsigned REG_NUM       = 1 << REG_NUM_BIT;
   localparam int unsigned DATA_WIDTH    = 32;

   typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/reg_file_rename_read_port.sv
// One combinational operand lookup: value/busy/tag for a register index,
// with a same-cycle bypass of a retiring result that matches the current tag.
module reg_read_port
   import reg_file_rename_pkg::*;
#(
   parameter int unsigned ROB_WIDTH_BIT = reg_file_rename_pkg::ROB_WIDTH_BIT,
   parameter int unsigned REG_NUM_BIT   = reg_file_rename_pkg::REG_NUM_BIT,
   parameter int unsigned NUM           = 1 << REG_NUM_BIT
) (
   input  logic [REG_NUM_BIT-1:0]   id,
   input  data_t                    regs [NUM],
   input  logic [NUM-1:0]           busy_vec,
   input  logic [ROB_WIDTH_BIT-1:0] tags [NUM],
   input  logic                     commit_valid,
   input  logic [REG_NUM_BIT-1:0]   commit_reg_id,
   input  data_t                    commit_val,
   input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
   output data_t                    val,
   output logic                     busy,
   output logic [ROB_WIDTH_BIT-1:0] rob_id
);

   always_comb begin
      val    = '0;
      busy   = 1'b0;
      rob_id = '0;
      if (id != '0) begin
         val    = regs[id];
         busy   = busy_vec[id];
         rob_id = tags[id];
         // Only the producer the register is still waiting on may bypass.
         if (commit_valid && commit_reg_id == id && busy_vec[id] &&
             tags[id] == commit_rob_id) begin
            val  = commit_val;
            busy = 1'b0;
         end
      end
   end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, updated by the
// ROB commit and rename streams and read by the Decoder through two ports.
module reg_file_rename
   import reg_file_rename_pkg::*;
#(
   parameter int unsigned ROB_WIDTH_BIT = reg_file_rename_pkg::ROB_WIDTH_BIT,
   parameter int unsigned REG_NUM_BIT   = reg_file_rename_pkg::REG_NUM_BIT
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     clear,
   input  logic                     commit_valid,
   input  logic [REG_NUM_BIT-1:0]   commit_reg_id,
   input  logic [31:0]              commit_val,
   input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
   input  logic                     rename_valid,
   input  logic [REG_NUM_BIT-1:0]   rename_reg_id,
   input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
   input  logic [REG_NUM_BIT-1:0]   rs1_id,
   output logic [31:0]              rs1_val,
   output logic                     rs1_busy,
   output logic [ROB_WIDTH_BIT-1:0] rs1_rob_id,
   input  logic [REG_NUM_BIT-1:0]   rs2_id,
   output logic [31:0]              rs2_val,
   output logic                     rs2_busy,
   output logic [ROB_WIDTH_BIT-1:0] rs2_rob_id
);

   localparam int unsigned NUM = 1 << REG_NUM_BIT;

   data_t                    regs [NUM];
   logic [NUM-1:0]           busy;
   logic [ROB_WIDTH_BIT-1:0] tags [NUM];

   // Later non-blocking writes take priority: clear/rename override the
   // commit's busy release for the same register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy <= '0;
         for (int unsigned i = 0; i < NUM; i++) begin
            regs[i] <= '0;
            tags[i] <= '0;
         end
      end else if (rdy_in) begin
         if (commit_valid && commit_reg_id != '0) begin
            regs[commit_reg_id] <= commit_val;
            if (busy[commit_reg_id] && tags[commit_reg_id] == commit_rob_id)
               busy[commit_reg_id] <= 1'b0;
         end
         if (clear) begin
            busy <= '0;
            for (int unsigned i = 0; i < NUM; i++)
               tags[i] <= '0;
         end else if (rename_valid && rename_reg_id != '0) begin
            busy[rename_reg_id] <= 1'b1;
            tags[rename_reg_id] <= rename_rob_id;
         end
      end
   end

   reg_read_port #(
      .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
      .REG_NUM_BIT   (REG_NUM_BIT),
      .NUM           (NUM)
   ) u_rs1 (
      .id            (rs1_id),
      .regs          (regs),
      .busy_vec      (busy),
      .tags          (tags),
      .commit_valid  (commit_valid),
      .commit_reg_id (commit_reg_id),
      .commit_val    (commit_val),
      .commit_rob_id (commit_rob_id),
      .val           (rs1_val),
      .busy          (rs1_busy),
      .rob_id        (rs1_rob_id)
   );

   reg_read_port #(
      .ROB_WIDTH_BIT (ROB_WIDTH_BIT),
      .REG_NUM_BIT   (REG_NUM_BIT),
      .NUM           (NUM)
   ) u_rs2 (
      .id            (rs2_id),
      .regs          (regs),
      .busy_vec      (busy),
      .tags          (tags),
      .commit_valid  (commit_valid),
      .commit_reg_id (commit_reg_id),
      .commit_val    (commit_val),
      .commit_rob_id (commit_rob_id),
      .val           (rs2_val),
      .busy          (rs2_busy),
      .rob_id        (rs2_rob_id)
   );

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename: expected reads are queued as stimulus
// is driven and compared against the combinational read ports.
module tb_reg_file_rename;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear;
   logic        commit_valid, rename_valid;
   logic [4:0]  commit_reg_id, rename_reg_id, rs1_id, rs2_id;
   logic [31:0] commit_val, rs1_val, rs2_val;
   logic [3:0]  commit_rob_id, rename_rob_id, rs1_rob_id, rs2_rob_id;
   logic        rs1_busy, rs2_busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      bit          port;
      logic [31:0] val;
      logic        busy;
      logic [3:0]  rob;
   } exp_t;
   exp_t sb[$];

   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic [3:0]  m_tag  [32];

   always #5 clk_in = ~clk_in;

   reg_file_rename #(.ROB_WIDTH_BIT(4), .REG_NUM_BIT(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .commit_valid(commit_valid), .commit_reg_id(commit_reg_id),
      .commit_val(commit_val), .commit_rob_id(commit_rob_id),
      .rename_valid(rename_valid), .rename_reg_id(rename_reg_id),
      .rename_rob_id(rename_rob_id),
      .rs1_id(rs1_id), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_rob_id(rs1_rob_id),
      .rs2_id(rs2_id), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_rob_id(rs2_rob_id)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string t, input bit p, input logic [31:0] v,
                           input logic b, input logic [3:0] r);
      exp_t e;
      e.tag = t; e.port = p; e.val = v; e.busy = b; e.rob = r;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.port) begin
            check_eq({e.tag, ".val"},  rs1_val,           e.val);
            check_eq({e.tag, ".busy"}, 32'(rs1_busy),     32'(e.busy));
            check_eq({e.tag, ".rob"},  32'(rs1_rob_id),   32'(e.rob));
         end else begin
            check_eq({e.tag, ".val"},  rs2_val,           e.val);
            check_eq({e.tag, ".busy"}, 32'(rs2_busy),     32'(e.busy));
            check_eq({e.tag, ".rob"},  32'(rs2_rob_id),   32'(e.rob));
         end
      end
   endtask

   task automatic model_exp(input string t, input bit p, input logic [4:0] id);
      logic [31:0] v = '0;
      logic        b = 1'b0;
      logic [3:0]  r = '0;
      if (id != 0) begin
         v = m_regs[id]; b = m_busy[id]; r = m_tag[id];
         if (commit_valid && commit_reg_id == id && m_busy[id] && m_tag[id] == commit_rob_id) begin
            v = commit_val; b = 1'b0;
         end
      end
      push_exp(t, p, v, b, r);
   endtask

   task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
      rs1_id = a; rs2_id = b;
      model_exp("model_rs1", 1'b0, a);
      model_exp("model_rs2", 1'b1, b);
   endtask

   task automatic model_reset();
      m_busy = '0;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0; m_tag[i] = '0;
      end
   endtask

   task automatic model_tick();
      if (!rst_in) model_reset();
      else if (rdy_in) begin
         if (commit_valid && commit_reg_id != 0) begin
            if (m_busy[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_id)
               m_busy[commit_reg_id] = 1'b0;
            m_regs[commit_reg_id] = commit_val;
         end
         if (clear) begin
            m_busy = '0;
            for (int i = 0; i < 32; i++) m_tag[i] = '0;
         end else if (rename_valid && rename_reg_id != 0) begin
            m_busy[rename_reg_id] = 1'b1;
            m_tag[rename_reg_id]  = rename_rob_id;
         end
      end
   endtask

   task automatic idle();
      rdy_in = 1'b1; clear = 1'b0;
      commit_valid = 1'b0; commit_reg_id = '0; commit_val = '0; commit_rob_id = '0;
      rename_valid = 1'b0; rename_reg_id = '0; rename_rob_id = '0;
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] v);
      commit_valid = 1'b1; commit_reg_id = rd; commit_rob_id = rob; commit_val = v;
   endtask

   task automatic do_rename(input logic [4:0] rd, input logic [3:0] rob);
      rename_valid = 1'b1; rename_reg_id = rd; rename_rob_id = rob;
   endtask

   task automatic cyc();
      #1 drain();
      @(posedge clk_in);
      model_tick();
      @(negedge clk_in);
   endtask

   initial begin
      model_reset();
      idle();
      rst_in = 1'b0;
      set_reads(5'd5, 5'd0);
      push_exp("reset_x5", 1'b0, 32'h0, 1'b0, 4'h0);
      #1 drain();
      @(negedge clk_in);
      rst_in = 1'b1;

      // x0 ignores commits
      do_commit(5'd0, 4'd0, 32'hFF); set_reads(5'd0, 5'd5); cyc();
      idle(); set_reads(5'd0, 5'd0);
      push_exp("x0_after_commit", 1'b0, 32'h0, 1'b0, 4'h0); cyc();

      // rename then commit x3 with bypass
      do_rename(5'd3, 4'd2); set_reads(5'd3, 5'd0); cyc();
      idle(); set_reads(5'd3, 5'd0);
      push_exp("x3_renamed", 1'b0, 32'h0, 1'b1, 4'd2); cyc();
      do_commit(5'd3, 4'd2, 32'h1234); set_reads(5'd3, 5'd3);
      push_exp("x3_bypass", 1'b1, 32'h1234, 1'b0, 4'd2); cyc();
      idle(); set_reads(5'd3, 5'd0);
      push_exp("x3_committed", 1'b0, 32'h1234, 1'b0, 4'd2); cyc();

      // older commit must not release a younger rename
      do_rename(5'd4, 4'd1); set_reads(5'd4, 5'd3); cyc();
      idle(); do_rename(5'd4, 4'd5); set_reads(5'd4, 5'd3); cyc();
      idle(); do_commit(5'd4, 4'd1, 32'hAA); set_reads(5'd4, 5'd0);
      push_exp("x4_stale_commit", 1'b0, 32'h0, 1'b1, 4'd5); cyc();
      idle(); set_reads(5'd4, 5'd0);
      push_exp("x4_still_busy", 1'b0, 32'hAA, 1'b1, 4'd5); cyc();

      // same-cycle commit and rename of x6
      do_rename(5'd6, 4'd3); set_reads(5'd6, 5'd4); cyc();
      idle(); do_commit(5'd6, 4'd3, 32'h77); do_rename(5'd6, 4'd7); set_reads(5'd6, 5'd6);
      push_exp("x6_same_cycle", 1'b0, 32'h77, 1'b0, 4'd3); cyc();
      idle(); set_reads(5'd6, 5'd0);
      push_exp("x6_rename_wins", 1'b0, 32'h77, 1'b1, 4'd7); cyc();

      // rename every register, then clear with an in-flight commit of x2
      for (int i = 1; i < 32; i++) begin
         idle(); do_rename(5'(i), 4'(i));
         set_reads(5'($urandom_range(0, 31)), 5'(i)); cyc();
      end
      idle(); clear = 1'b1; do_commit(5'd2, 4'd2, 32'h55); do_rename(5'd9, 4'd1);
      set_reads(5'd2, 5'd9);
      push_exp("clr_x2_bypass", 1'b0, 32'h55, 1'b0, 4'd2);
      push_exp("clr_x9_prior", 1'b1, 32'h0, 1'b1, 4'd9); cyc();
      idle(); set_reads(5'd2, 5'd9);
      push_exp("after_clr_x2", 1'b0, 32'h55, 1'b0, 4'd0);
      push_exp("after_clr_x9", 1'b1, 32'h0, 1'b0, 4'd0); cyc();
      for (int i = 0; i < 32; i++) begin
         idle(); set_reads(5'(i), 5'(31 - i));
         push_exp("after_clr_idle", 1'b0, m_regs[i], 1'b0, 4'd0); cyc();
      end

      // paused cycle changes nothing
      idle(); rdy_in = 1'b0; do_commit(5'd3, 4'd0, 32'hDEAD); do_rename(5'd8, 4'd9);
      set_reads(5'd3, 5'd8); cyc();
      idle(); set_reads(5'd3, 5'd8);
      push_exp("pause_x3", 1'b0, 32'h1234, 1'b0, 4'd0);
      push_exp("pause_x8", 1'b1, 32'h0, 1'b0, 4'd0); cyc();

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [4:0] rd;
         idle();
         rdy_in = ($urandom_range(0, 7) != 0);
         clear  = ($urandom_range(0, 19) == 0);
         rd = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) != 0)
            do_commit(rd, ($urandom_range(0, 3) != 0) ? m_tag[rd] : 4'($urandom), $urandom);
         if ($urandom_range(0, 2) != 0)
            do_rename(5'($urandom_range(0, 31)), 4'($urandom));
         set_reads(($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)));
         cyc();
      end

      // asynchronous reset takes effect without a clock edge
      idle(); do_rename(5'd2, 4'd4); do_commit(5'd6, 4'd1, 32'h99); cyc();
      idle(); #2 rst_in = 1'b0; model_reset();
      set_reads(5'd2, 5'd6);
      push_exp("async_rst_x2", 1'b0, 32'h0, 1'b0, 4'd0);
      push_exp("async_rst_x6", 1'b1, 32'h0, 1'b0, 4'd0);
      #1 drain();
      @(negedge clk_in);
      rst_in = 1'b1;
      set_reads(5'd6, 5'd31); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
